drv_display: RTL and testbench



---
 rtl/drv_display.sv | 122 ++++++++++++
 tb/tb_drv_display.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/drv_display.sv
// Three-digit multiplexed 7-segment driver for a common-anode display.
// Captures keypad codes into a 3-slot buffer and scans them out, dp marking the entry position.
module drv_display #(
  parameter int PRESC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] digito,
  input  logic [1:0] desp,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int            PW   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESC - 1);
  localparam logic [4:0]    BLANK_CODE = 5'd16;

  logic [4:0]    slot0_q, slot1_q, slot2_q;
  logic [4:0]    slot0_d, slot1_d, slot2_d;
  logic [1:0]    desp_q,  desp_d;
  logic [PW-1:0] pcnt_q,  pcnt_d;
  logic [1:0]    idx_q,   idx_d;
  logic [2:0]    an_q,    an_d;
  logic [6:0]    seg_q,   seg_d;
  logic          dp_q,    dp_d;
  logic [4:0]    cur_code;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..15 is blank.
  function automatic logic [6:0] dec(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'b1000000;
      5'd1:    s = 7'b1111001;
      5'd2:    s = 7'b0100100;
      5'd3:    s = 7'b0110000;
      5'd4:    s = 7'b0011001;
      5'd5:    s = 7'b0010010;
      5'd6:    s = 7'b0000010;
      5'd7:    s = 7'b1111000;
      5'd8:    s = 7'b0000000;
      5'd9:    s = 7'b0010000;
      5'd10:   s = 7'b0001000;
      5'd11:   s = 7'b0000011;
      5'd12:   s = 7'b1000110;
      5'd13:   s = 7'b0100001;
      5'd14:   s = 7'b0000110;
      5'd15:   s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Capture: a pointer move commits the digit typed at the old position.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    slot2_d = slot2_q;
    desp_d  = desp;
    if (desp != desp_q) begin
      case (desp_q)
        2'd0:    slot0_d = digito;
        2'd1:    slot1_d = digito;
        2'd2:    slot2_d = digito;
        default: ;
      endcase
    end
  end

  // Scan: prescaler wrap advances the digit index; an illegal index recovers to 0.
  always_comb begin
    pcnt_d = pcnt_q + 1'b1;
    idx_d  = idx_q;
    if (pcnt_q >= PMAX) begin
      pcnt_d = '0;
      idx_d  = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
    if (idx_q == 2'd3)
      idx_d = 2'd0;
  end

  always_comb begin
    case (idx_q)
      2'd0:    cur_code = slot0_q;
      2'd1:    cur_code = slot1_q;
      2'd2:    cur_code = slot2_q;
      default: cur_code = BLANK_CODE;
    endcase
    an_d  = ~(3'b001 << idx_q);
    seg_d = dec(cur_code);
    dp_d  = (idx_q == desp_q) ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= BLANK_CODE;
      slot1_q <= BLANK_CODE;
      slot2_q <= BLANK_CODE;
      desp_q  <= 2'd0;
      pcnt_q  <= '0;
      idx_q   <= 2'd0;
      an_q    <= 3'b111;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      slot2_q <= slot2_d;
      desp_q  <= desp_d;
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_drv_display.sv
// Directed bench for drv_display: three instances (PRESC 4, 8, 1) share the keypad inputs.
module tb_drv_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] digito = 5'd0;
  logic [1:0] desp = 2'd0;
  logic [2:0] an4, an8, an1;
  logic [6:0] seg4, seg8, seg1;
  logic       dp4, dp8, dp1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  drv_display #(.PRESC(4)) u4 (.clk(clk), .rst_n(rst_n), .digito(digito), .desp(desp),
                               .an(an4), .seg(seg4), .dp(dp4));
  drv_display #(.PRESC(8)) u8 (.clk(clk), .rst_n(rst_n), .digito(digito), .desp(desp),
                               .an(an8), .seg(seg8), .dp(dp8));
  drv_display #(.PRESC(1)) u1 (.clk(clk), .rst_n(rst_n), .digito(digito), .desp(desp),
                               .an(an1), .seg(seg1), .dp(dp1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Three PRESC=1 edges cover every slot once; seg/dp judged by which anode is lit.
  task automatic check_u1(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                          input logic [6:0] s2, input int dpslot);
    int s;
    for (int k = 0; k < 3; k++) begin
      step();
      case (an1)
        3'b110:  s = 0;
        3'b101:  s = 1;
        3'b011:  s = 2;
        default: s = -1;
      endcase
      if (s < 0) begin
        check({tag, "_an"}, an1, 3'b110);
      end else begin
        check({tag, "_seg"}, seg1, (s == 0) ? s0 : (s == 1) ? s1 : s2);
        check({tag, "_dp"}, dp1, (s == dpslot) ? 1'b0 : 1'b1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] e4, e8, e1;
    int n;

    // Reset held from time zero
    @(negedge clk);
    @(negedge clk);
    check("rst_an", an4, 3'b111);
    check("rst_seg", seg4, 7'h7F);
    check("rst_dp", dp4, 1'b1);
    rst_n = 1'b1;

    // Scan rotation, no input
    for (int e = 1; e <= 12; e++) begin
      step();
      e4 = (e <= 4) ? 3'b110 : (e <= 8) ? 3'b101 : 3'b011;
      e8 = (e <= 8) ? 3'b110 : 3'b101;
      e1 = (e % 3 == 1) ? 3'b110 : (e % 3 == 2) ? 3'b101 : 3'b011;
      check("rot4_an", an4, e4);
      check("rot4_dp", dp4, (e4 == 3'b110) ? 1'b0 : 1'b1);
      check("rot4_seg", seg4, 7'h7F);
      check("rot8_an", an8, e8);
      check("rot1_an", an1, e1);
    end

    // Asynchronous reset mid-scan
    #2 rst_n = 1'b0;
    #1;
    check("async_an", an4, 3'b111);
    check("async_seg", seg4, 7'h7F);
    check("async_dp", dp4, 1'b1);
    check("async_an1", an1, 3'b111);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rel_an", an4, 3'b110);
    check("rel_seg", seg4, 7'h7F);
    check("rel_dp", dp4, 1'b0);

    // Capture 5 at position 0, pointer moves to 1
    digito = 5'd5;
    desp = 2'd1;
    step();
    check("cap_k_seg", seg4, 7'h7F);
    check("cap_k_dp", dp4, 1'b0);
    step();
    check("cap_k1_an", an4, 3'b110);
    check("cap_k1_seg", seg4, 7'b0010010);
    check("cap_k1_dp", dp4, 1'b1);
    step();
    step();
    check("cap_s1_an", an4, 3'b101);
    check("cap_s1_seg", seg4, 7'h7F);
    check("cap_s1_dp", dp4, 1'b0);

    // Fresh start, then full entry 1, A, F on back-to-back pointer moves
    #2 rst_n = 1'b0;
    desp = 2'd0;
    digito = 5'd0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    digito = 5'd1;  desp = 2'd1;
    step();
    digito = 5'd10; desp = 2'd2;
    step();
    digito = 5'd15; desp = 2'd0;
    step();
    digito = 5'd7;
    check_u1("entry", 7'b1111001, 7'b0001000, 7'b0001110, 0);
    check_u1("nowrite", 7'b1111001, 7'b0001000, 7'b0001110, 0);

    // Invalid code 17 into slot 0, 9 into slot 1, then pointer parks at 3
    digito = 5'd17; desp = 2'd1;
    step();
    digito = 5'd9;  desp = 2'd3;
    step();
    digito = 5'd4;
    check_u1("ptr3", 7'h7F, 7'b0010000, 7'b0001110, 3);
    desp = 2'd0;
    step();
    check_u1("drop3", 7'h7F, 7'b0010000, 7'b0001110, 0);

    // Write slot 0 while PRESC=8 instance is displaying it
    n = 0;
    while (an8 == 3'b110 && n < 40) begin step(); n++; end
    while (an8 != 3'b110 && n < 40) begin step(); n++; end
    check("wr_reach_slot0", (an8 == 3'b110), 1'b1);
    check("wr_before_seg", seg8, 7'h7F);
    digito = 5'd12;
    desp = 2'd1;
    step();
    check("wr_k_an", an8, 3'b110);
    check("wr_k_seg", seg8, 7'h7F);
    step();
    check("wr_k1_an", an8, 3'b110);
    check("wr_k1_seg", seg8, 7'b1000110);
    check("wr_k1_dp", dp8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
